// File: rtl/nvme_arb_pkg.sv
// Shared types and helpers for the NVMe TX buffer read-port arbiter.
package nvme_arb_pkg;

   // Arbiter ownership state: no owner, or a locked owner holds the port.
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   // Bits needed to hold an index in 0..n-1, never less than one bit.
   function automatic int idx_bits(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nvme_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclically.
module nvme_rr_pick
   import nvme_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = idx_bits(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      gnt_idx_o,
   output logic               gnt_valid_o
);

   // Scan NUM_REQ positions starting at the pointer; the first hit wins.
   always_comb begin
      int idx;
      idx         = 0;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!gnt_valid_o && req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IW'(idx);
            gnt_o[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nvme_tx_buf_arbiter.sv
// Round-robin arbiter sharing the NVMe TX buffer read port, with burst lock,
// hold limit, and fixed-latency tagged return of read data.
module nvme_tx_buf_arbiter
   import nvme_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_BITS  = 12,
   parameter int DATA_BITS  = 128,
   parameter int RD_LATENCY = 1,
   parameter int MAX_HOLD   = 16
) (
   input  logic                         axi_aclk,
   input  logic                         axi_aresetn,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
   input  logic [NUM_REQ-1:0]           req_lock,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_BITS-1:0]         rsp_data,
   output logic                         buf_read,
   output logic [ADDR_BITS-1:0]         buf_raddr,
   input  logic [DATA_BITS-1:0]         buf_rdata,
   output logic                         busy
);

   localparam int IW        = idx_bits(NUM_REQ);
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int HW        = idx_bits(HOLD_LAST + 1);
   localparam int DEPTH     = RD_LATENCY + 1;

   arb_state_e                 state_q, state_d;
   logic [IW-1:0]              owner_q, owner_d;
   logic [HW-1:0]              hold_q, hold_d;
   logic [IW-1:0]              rr_q;
   logic [IW-1:0]              pick_ptr;
   logic [NUM_REQ-1:0]         pick_gnt;
   logic [IW-1:0]              pick_idx;
   logic                       pick_valid;
   logic                       use_pick;
   logic [NUM_REQ-1:0]         gnt;
   logic [IW-1:0]              gnt_idx;
   logic                       accept;
   logic [NUM_REQ-1:0]         owner_oh;
   logic                       owner_lock;
   logic                       other_valid;
   logic                       hold_at_limit;
   logic                       buf_read_q;
   logic [ADDR_BITS-1:0]       buf_raddr_q;
   logic [DEPTH-1:0][IW-1:0]   tag_q;
   logic [DEPTH-1:0]           tag_vld_q;
   logic [NUM_REQ-1:0]         rsp_hit;
   logic [NUM_REQ-1:0]         rsp_valid_q;
   logic [DATA_BITS-1:0]       rsp_data_q;

   // Successor index with wrap at NUM_REQ (NUM_REQ need not be a power of two).
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IW'(1);
   endfunction

   genvar gi;
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign owner_oh[gi] = (owner_q == IW'(gi));
      assign rsp_hit[gi]  = tag_vld_q[DEPTH-1] && (tag_q[DEPTH-1] == IW'(gi));
   end

   assign owner_lock    = req_lock[owner_q];
   assign other_valid   = |(req_valid & ~owner_oh);
   assign hold_at_limit = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_LAST));

   // A releasing owner hands priority to the next index in the same cycle.
   assign pick_ptr = (state_q == ARB_OWNED) ? wrap_inc(owner_q) : rr_q;

   nvme_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req_i       (req_valid),
      .ptr_i       (pick_ptr),
      .gnt_o       (pick_gnt),
      .gnt_idx_o   (pick_idx),
      .gnt_valid_o (pick_valid)
   );

   // Grant selection and ownership next-state.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      hold_d   = hold_q;
      gnt      = '0;
      gnt_idx  = pick_idx;
      use_pick = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            use_pick = 1'b1;
         end
         ARB_OWNED: begin
            if (!owner_lock) begin
               // Voluntary release: arbitrate this very cycle.
               use_pick = 1'b1;
               state_d  = ARB_IDLE;
               hold_d   = '0;
            end else begin
               gnt     = owner_oh & req_valid;
               gnt_idx = owner_q;
               if (hold_at_limit && other_valid) begin
                  // Forced release: owner may finish this beat, others compete next cycle.
                  state_d = ARB_IDLE;
                  hold_d  = '0;
               end else if (hold_q != HW'(HOLD_LAST)) begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      if (use_pick) begin
         gnt     = pick_gnt;
         gnt_idx = pick_idx;
         if (pick_valid && req_lock[pick_idx]) begin
            state_d = ARB_OWNED;
            owner_d = pick_idx;
            hold_d  = '0;
         end
      end
   end

   assign accept    = |gnt;
   assign req_ready = gnt;

   // Ownership, hold counter and round-robin pointer.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         hold_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         if (accept) begin
            rr_q <= wrap_inc(gnt_idx);
         end
      end
   end

   // Issue the accepted read to the buffer and track its tag until data returns.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         buf_read_q  <= 1'b0;
         buf_raddr_q <= '0;
         tag_q       <= '0;
         tag_vld_q   <= '0;
      end else begin
         buf_read_q   <= accept;
         if (accept) begin
            buf_raddr_q <= req_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
         end
         tag_vld_q[0] <= accept;
         tag_q[0]     <= gnt_idx;
         for (int k = 1; k < DEPTH; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_q[k]     <= tag_q[k-1];
         end
      end
   end

   // Capture returning data and strobe the originating requester.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_hit;
         if (tag_vld_q[DEPTH-1]) begin
            rsp_data_q <= buf_rdata;
         end
      end
   end

   assign buf_read  = buf_read_q;
   assign buf_raddr = buf_raddr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q == ARB_OWNED) || (|tag_vld_q);

endmodule
